// File: rtl/run_sequencer.sv
// -----------------------------------------------------------------------------
// run_sequencer
//
// Purpose:
//   Sequences one program run of the 9-bit core. It also arbitrates the
//   single-port DataMemory between the core's memory path and a host
//   preload/readback port.
//   - The core is held in reset while the host preloads memory.
//   - On start, the core is released and DataMemory is handed to the core.
//   - On halt (or watchdog expiry), done is raised and DataMemory returns
//     to the host.
//
// Memory ownership is decided by the state register only:
//   IDLE -> host
//   ARM  -> nobody
//   RUN  -> core
//   DONE -> host
//
// Optional feature:
//   RUN_WATCHDOG_EN  When defined, a run is ended after MAX_CYCLES RUN cycles
//                    without a halt, and timeout is raised. When undefined,
//                    timeout is tied low and a run lasts until core_halt.
//
// Parameters:
//   ADDR_W      DataMemory address width
//   DATA_W      DataMemory data width
//   MAX_CYCLES  watchdog limit in RUN cycles, 2..65535
//
// Ports:
//   clk          clock, all state on posedge
//   reset_n      asynchronous active-low reset
//   start        begins a run from IDLE or DONE (ignored in ARM/RUN)
//   host_req     host access request
//   host_we      host write (1) / read (0)
//   host_addr    host address
//   host_wdata   host write data
//   host_gnt     host access accepted this cycle
//   host_rdata   DataMemory read data for the host
//   core_addr    core memory address
//   core_wdata   core write data
//   core_we      core write enable
//   core_rdata   DataMemory read data for the core
//   core_halt    core halt indication
//   dm_addr      DataMemory address
//   dm_wdata     DataMemory write data
//   dm_we        DataMemory write enable
//   dm_rdata     DataMemory combinational read data
//   core_rst     active-high reset to the core
//   done         run finished; held until the next run is armed
//   timeout      run ended by the watchdog rather than by halt
//   cycle_count  RUN cycles of the current/last run (saturating)
// -----------------------------------------------------------------------------
module run_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int MAX_CYCLES = 4096
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_gnt,
   output logic [DATA_W-1:0] host_rdata,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   input  logic              core_we,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              core_halt,
   output logic [ADDR_W-1:0] dm_addr,
   output logic [DATA_W-1:0] dm_wdata,
   output logic              dm_we,
   input  logic [DATA_W-1:0] dm_rdata,
   output logic              core_rst,
   output logic              done,
   output logic              timeout,
   output logic [15:0]       cycle_count
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } stateT;

   stateT state;
   stateT nextState;
   logic  watchdogHit;

   // Elaboration-time guard on the watchdog limit.
   if (MAX_CYCLES < 2 || MAX_CYCLES > 65535) begin : gBadMaxCycles
      $error("run_sequencer: MAX_CYCLES must be in 2..65535");
   end

   function automatic logic [15:0] satInc16(input logic [15:0] value);
      if (value == 16'hFFFF) begin
         return value;
      end
      return value + 16'd1;
   endfunction

`ifdef RUN_WATCHDOG_EN
   localparam logic [15:0] WatchdogLast = 16'(MAX_CYCLES - 1);

   // Halt takes priority, so the watchdog only fires on a non-halt cycle.
   assign watchdogHit = (state == RUN) && !core_halt && (cycle_count == WatchdogLast);
`else
   assign watchdogHit = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = ARM;
         ARM:     nextState = RUN;
         RUN:     if (core_halt || watchdogHit) nextState = DONE;
         DONE:    if (start) nextState = ARM;
         default: nextState = IDLE;
      endcase
   end

   // Output / ownership mux, driven from the state register only.
   // In ARM the memory is idle: the core address is presented,
   // but no write is allowed.
   always_comb begin
      core_rst = 1'b1;
      host_gnt = 1'b0;
      dm_addr  = host_addr;
      dm_wdata = host_wdata;
      dm_we    = 1'b0;
      case (state)
         IDLE: begin
            core_rst = 1'b1;
            host_gnt = host_req;
            dm_we    = host_req & host_we;
         end
         ARM: begin
            core_rst = 1'b1;
            dm_addr  = core_addr;
            dm_wdata = core_wdata;
         end
         RUN: begin
            core_rst = 1'b0;
            dm_addr  = core_addr;
            dm_wdata = core_wdata;
            dm_we    = core_we;
         end
         DONE: begin
            // The core is left running out of reset, but its writes are masked.
            core_rst = 1'b0;
            host_gnt = host_req;
            dm_we    = host_req & host_we;
         end
         default: begin
            core_rst = 1'b1;
         end
      endcase
   end

   assign host_rdata = dm_rdata;
   assign core_rdata = dm_rdata;

   // Run bookkeeping.
   // The cycle counter also counts the cycle in which the run ends.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cycle_count <= 16'd0;
         done        <= 1'b0;
      end else begin
         case (state)
            ARM: begin
               cycle_count <= 16'd0;
               done        <= 1'b0;
            end
            RUN: begin
               cycle_count <= satInc16(cycle_count);
               if (core_halt || watchdogHit) begin
                  done <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

`ifdef RUN_WATCHDOG_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout <= 1'b0;
      end else if (state == ARM) begin
         timeout <= 1'b0;
      end else if (state == RUN) begin
         if (core_halt) begin
            timeout <= 1'b0;
         end else if (watchdogHit) begin
            timeout <= 1'b1;
         end
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
module tb_run_sequencer;

   localparam int ADDR_W     = 8;
   localparam int DATA_W     = 8;
   localparam int MAX_CYCLES = 16;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              start = 1'b0;
   logic              host_req = 1'b0;
   logic              host_we = 1'b0;
   logic [ADDR_W-1:0] host_addr = '0;
   logic [DATA_W-1:0] host_wdata = '0;
   logic              host_gnt;
   logic [DATA_W-1:0] host_rdata;
   logic [ADDR_W-1:0] core_addr = '0;
   logic [DATA_W-1:0] core_wdata = '0;
   logic              core_we = 1'b0;
   logic [DATA_W-1:0] core_rdata;
   logic              core_halt = 1'b0;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_we;
   logic [DATA_W-1:0] dm_rdata;
   logic              core_rst;
   logic              done;
   logic              timeout;
   logic [15:0]       cycle_count;

   int nAsserts = 0;
   int nFails   = 0;

   // DataMemory model: combinational read, write on the clock edge.
   logic [DATA_W-1:0] mem [256];

   always @(posedge clk) begin
      if (dm_we) mem[dm_addr] <= dm_wdata;
   end

   assign dm_rdata = mem[dm_addr];

   always #5 clk = ~clk;

   run_sequencer #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .MAX_CYCLES (MAX_CYCLES)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .start       (start),
      .host_req    (host_req),
      .host_we     (host_we),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_gnt    (host_gnt),
      .host_rdata  (host_rdata),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_we     (core_we),
      .core_rdata  (core_rdata),
      .core_halt   (core_halt),
      .dm_addr     (dm_addr),
      .dm_wdata    (dm_wdata),
      .dm_we       (dm_we),
      .dm_rdata    (dm_rdata),
      .core_rst    (core_rst),
      .done        (done),
      .timeout     (timeout),
      .cycle_count (cycle_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;

      // Reset state
      repeat (2) tick();
      check("rst core_rst", core_rst, 1);
      check("rst done", done, 0);
      check("rst timeout", timeout, 0);
      check("rst cycle_count", cycle_count, 0);
      check("rst host_gnt", host_gnt, 0);
      reset_n = 1'b1;

      // Preload: write 0x10 = 0xA5, then read it back
      host_req = 1'b1; host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
      #1;
      check("pre wr gnt", host_gnt, 1);
      check("pre wr dm_we", dm_we, 1);
      check("pre wr dm_addr", dm_addr, 8'h10);
      tick();
      host_we = 1'b0;
      #1;
      check("pre rd gnt", host_gnt, 1);
      check("pre rd host_rdata", host_rdata, 8'hA5);
      check("pre rd core_rdata", core_rdata, 8'hA5);
      tick();

      // start together with a host write in IDLE: still granted
      start = 1'b1; host_we = 1'b1; host_addr = 8'h11; host_wdata = 8'h5A;
      #1;
      check("start gnt", host_gnt, 1);
      tick();

      // ARM: nobody owns memory; core write is masked
      start = 1'b0; host_we = 1'b0;
      core_we = 1'b1; core_addr = 8'h30; core_wdata = 8'h77;
      #1;
      check("arm gnt", host_gnt, 0);
      check("arm dm_we", dm_we, 0);
      check("arm core_rst", core_rst, 1);
      tick();

      // RUN: host read of 0x11 held; core writes 0x20 = 0x3C; halt on 6th cycle
      for (int c = 1; c <= 6; c++) begin
         core_we    = (c == 2);
         core_addr  = 8'h20;
         core_wdata = 8'h3C;
         core_halt  = (c == 6);
         start      = (c == 3);
         #1;
         check("run core_rst", core_rst, 0);
         check("run host_gnt", host_gnt, 0);
         if (c == 1) begin
            check("run1 cycle_count", cycle_count, 0);
            check("run1 done", done, 0);
         end
         if (c == 2) begin
            check("run wr dm_we", dm_we, 1);
            check("run wr dm_addr", dm_addr, 8'h20);
         end
         tick();
      end

      // DONE: host gets memory back in the first cycle
      core_halt = 1'b0; core_we = 1'b0; start = 1'b0;
      #1;
      check("done gnt", host_gnt, 1);
      check("done rd 0x11", host_rdata, 8'h5A);
      check("done done", done, 1);
      check("done cycle_count", cycle_count, 6);
      check("done timeout", timeout, 0);
      check("done core_rst", core_rst, 0);
      tick();
      host_addr = 8'h20;
      #1;
      check("done rd 0x20", host_rdata, 8'h3C);
      tick();

      // Mask: core write in DONE must not land
      host_req = 1'b0; core_we = 1'b1; core_addr = 8'h20; core_wdata = 8'hFF;
      #1;
      check("mask dm_we", dm_we, 0);
      tick();
      core_we = 1'b0; host_req = 1'b1; host_addr = 8'h20;
      #1;
      check("mask rd 0x20", host_rdata, 8'h3C);
      tick();
      host_addr = 8'h30;
      #1;
      check("arm mask rd 0x30", host_rdata, 8'h00);
      check("frozen cycle_count", cycle_count, 6);
      tick();

      // Second run: no halt until the watchdog, or a long run without one
      host_req = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check("arm2 core_rst", core_rst, 1);
      tick();
`ifdef RUN_WATCHDOG_EN
      for (int c = 1; c <= MAX_CYCLES; c++) begin
         #1;
         check("wd run core_rst", core_rst, 0);
         check("wd run done", done, 0);
         tick();
      end
      #1;
      check("wd done", done, 1);
      check("wd timeout", timeout, 1);
      check("wd cycle_count", cycle_count, 16);
      check("wd core_rst", core_rst, 0);
`else
      for (int c = 1; c <= 20; c++) begin
         core_halt = (c == 20);
         #1;
         check("long run core_rst", core_rst, 0);
         check("long run done", done, 0);
         tick();
      end
      core_halt = 1'b0;
      #1;
      check("long done", done, 1);
      check("long timeout", timeout, 0);
      check("long cycle_count", cycle_count, 20);
`endif
      tick();

      // Third run: rerun clears flags, then reset mid-RUN
      start = 1'b1;
      tick();
      start = 1'b0;
      #1;
      check("arm3 core_rst", core_rst, 1);
      tick();
      #1;
      check("run3 done", done, 0);
      check("run3 timeout", timeout, 0);
      check("run3 cycle_count", cycle_count, 0);
      tick();
      tick();
      host_req = 1'b1; host_we = 1'b0; host_addr = 8'h40;
      core_we = 1'b1; core_addr = 8'h40; core_wdata = 8'h99;
      #1;
      reset_n = 1'b0;
      #1;
      check("midrst core_rst", core_rst, 1);
      check("midrst done", done, 0);
      check("midrst cycle_count", cycle_count, 0);
      check("midrst timeout", timeout, 0);
      check("midrst host_gnt", host_gnt, 1);
      check("midrst dm_we", dm_we, 0);
      tick();
      reset_n = 1'b1; core_we = 1'b0;
      #1;
      check("midrst dropped wr", host_rdata, 8'h00);
      check("midrst idle core_rst", core_rst, 1);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
